// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
   localparam int              XLEN             = 32;
   localparam int              INSTR_BYTES      = 4;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries; the head entry is read straight from storage flops.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [CW-1:0] count,
   output fetch_entry_t head
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_push = push && (count != CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) rd_ptr <= bump(rd_ptr);
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests, buffers responses for decode.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr,
   input  logic            id_ready
);
   localparam int CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   inflight, occ, discard, discard_next, inflight_after;
   logic            gnt_fire, rsp_fire, buf_push, id_pop;
   fetch_entry_t    tag_in, tag_head, buf_in, buf_head;
   logic            unused_tag_instr;

   // Gated by rst_n so the request drops the instant reset asserts.
   assign imem_req  = rst_n && ((CW+1)'(inflight) + (CW+1)'(occ) < (CW+1)'(DEPTH));
   assign imem_addr = fetch_pc;

   assign gnt_fire       = imem_req & imem_gnt;
   assign rsp_fire       = imem_rvalid & (inflight != '0);
   assign buf_push       = rsp_fire & (discard == '0) & ~redirect_valid;
   assign id_pop         = id_valid & id_ready;
   assign inflight_after = inflight + CW'(gnt_fire) - CW'(rsp_fire);

   // After a redirect every request still outstanding is wrong-path, stale or not.
   always_comb begin
      discard_next = discard;
      if (rsp_fire && discard != '0) discard_next = discard - CW'(1);
      if (redirect_valid)            discard_next = inflight_after;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         discard  <= '0;
      end else begin
         discard <= discard_next;
         if (redirect_valid)  fetch_pc <= redirect_pc;
         else if (gnt_fire)   fetch_pc <= fetch_pc + XLEN'(INSTR_BYTES);
      end
   end

   // Tag queue: one PC per granted request; its occupancy is the in-flight count.
   assign tag_in           = '{pc: fetch_pc, instr: NOP_INSTR};
   assign unused_tag_instr = ^tag_head.instr;

   fetch_fifo #(.DEPTH(DEPTH)) u_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (gnt_fire),
      .push_data (tag_in),
      .pop       (rsp_fire),
      .flush     (1'b0),
      .count     (inflight),
      .head      (tag_head)
   );

   assign buf_in = '{pc: tag_head.pc, instr: imem_rdata};

   fetch_fifo #(.DEPTH(DEPTH)) u_ibuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (buf_push),
      .push_data (buf_in),
      .pop       (id_pop),
      .flush     (redirect_valid),
      .count     (occ),
      .head      (buf_head)
   );

   assign id_valid = (occ != '0);
   assign id_pc    = buf_head.pc;
   assign id_instr = buf_head.instr;

   a_rvalid_needs_inflight: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> inflight != '0);
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory responder model plus a scoreboard of expected decode deliveries.
module tb_instr_fetch_unit;
   localparam int          DEPTH = 2;
   localparam logic [31:0] K     = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_ready = 1'b0;

   instr_fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .id_ready       (id_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] epc;
      int          due;
      bit          live;
   } mreq_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;
   typedef struct {
      int          lat;
      int          gnt_pct;
      int          rdy_pct;
      int          mode;
      logic [31:0] tgt;
      int          cycles;
      logic [31:0] exp_first;
   } row_t;

   mreq_t       mq[$];
   exp_t        eq[$];
   logic [31:0] got_q[$];
   logic [31:0] mpc = '0;
   int          cyc = 0, n_cmp = 0, n_err = 0;
   int          lat = 1, gnt_pct = 100, rdy_pct = 100;
   bit          redir_done;
   row_t        rows[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic first_pc(input string name, input logic [31:0] exp);
      if (got_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: got no delivery expected pc %h", name, exp);
      end else chk(name, got_q[0], exp);
   endtask

   // mode 0: no redirect, 1: redirect, 2: redirect only if gnt and rvalid both fire this edge
   task automatic step(input int mode = 0, input logic [31:0] rpc = '0);
      bit    redir;
      mreq_t e;
      @(negedge clk);
      cyc++;
      chk("imem_req", 32'(imem_req), 32'(mq.size() + eq.size() < DEPTH));
      if (imem_req) chk("imem_addr", imem_addr, mpc);
      chk("id_valid", 32'(id_valid), 32'(eq.size() != 0));
      imem_gnt = ($urandom_range(99) < gnt_pct);
      id_ready = ($urandom_range(99) < rdy_pct);
      if (mq.size() != 0 && mq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mq[0].addr ^ K;
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = $urandom;
      end
      redir = (mode == 1) || (mode == 2 && imem_req && imem_gnt && imem_rvalid);
      redir_done     = redir;
      redirect_valid = redir;
      redirect_pc    = rpc;
      if (id_valid && id_ready) begin
         got_q.push_back(id_pc);
         if (eq.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL id_handshake: got pc %h expected no instruction", id_pc);
         end else begin
            chk("id_pc", id_pc, eq[0].pc);
            chk("id_instr", id_instr, eq[0].instr);
            void'(eq.pop_front());
         end
      end
      if (imem_rvalid) begin
         e = mq.pop_front();
         if (e.live && !redir) eq.push_back('{pc: e.epc, instr: e.epc ^ K});
      end
      if (imem_req && imem_gnt) begin
         mq.push_back('{addr: imem_addr, epc: mpc, due: cyc + lat, live: 1'b1});
         if (!redir) mpc = mpc + 32'd4;
      end
      if (redir) begin
         eq.delete();
         foreach (mq[i]) mq[i].live = 1'b0;
         mpc = rpc;
      end
   endtask

   task automatic quiet_inputs();
      redirect_valid = 1'b0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      id_ready       = 1'b0;
   endtask

   task automatic model_reset();
      mq.delete();
      eq.delete();
      mpc = 32'h0;
   endtask

   initial begin
      rows[0] = '{lat: 1, gnt_pct: 100, rdy_pct: 100, mode: 1, tgt: 32'h0000_1000, cycles: 20, exp_first: 32'h0000_1000};
      rows[1] = '{lat: 2, gnt_pct: 70,  rdy_pct: 60,  mode: 1, tgt: 32'h0000_2000, cycles: 40, exp_first: 32'h0000_2000};
      rows[2] = '{lat: 3, gnt_pct: 50,  rdy_pct: 100, mode: 1, tgt: 32'h0000_3000, cycles: 40, exp_first: 32'h0000_3000};
      rows[3] = '{lat: 1, gnt_pct: 100, rdy_pct: 100, mode: 2, tgt: 32'h0000_0200, cycles: 25, exp_first: 32'h0000_0200};
      rows[4] = '{lat: 4, gnt_pct: 100, rdy_pct: 30,  mode: 1, tgt: 32'hABCD_0000, cycles: 60, exp_first: 32'hABCD_0000};

      // Reset held for 3 cycles
      quiet_inputs();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_req", 32'(imem_req), 32'h0);
         chk("rst_valid", 32'(id_valid), 32'h0);
         chk("rst_addr", imem_addr, 32'h0);
         chk("rst_id_pc", id_pc, 32'h0);
         chk("rst_id_instr", id_instr, 32'h0);
      end
      rst_n = 1'b1;
      model_reset();

      // Streaming, then backpressure, then resume: one continuous sequence
      got_q.delete();
      lat = 1; gnt_pct = 100; rdy_pct = 100;
      repeat (20) step();
      rdy_pct = 0;
      repeat (6) step();
      chk("bp_req_off", 32'(imem_req), 32'h0);
      if (eq.size() != 0) chk("bp_hold_pc", id_pc, eq[0].pc);
      repeat (3) step();
      if (eq.size() != 0) chk("bp_hold_pc2", id_pc, eq[0].pc);
      rdy_pct = 100;
      repeat (12) step();
      chk("seq_len", 32'(got_q.size() >= 12), 32'h1);
      foreach (got_q[i]) chk("seq_pc", got_q[i], 32'(i * 4));

      // Redirect with two requests in flight
      lat = 3;
      for (int i = 0; i < 10 && mq.size() < 2; i++) step();
      chk("two_inflight", 32'(mq.size()), 32'd2);
      step(1, 32'h100);
      got_q.delete();
      @(posedge clk); #1;
      chk("redir_addr", imem_addr, 32'h100);
      repeat (15) step();
      first_pc("redir_first", 32'h100);

      // Same-cycle redirect + grant + response, then a second redirect two cycles later
      lat = 1;
      redir_done = 1'b0;
      for (int i = 0; i < 20 && !redir_done; i++) step(2, 32'h200);
      chk("same_cycle_hit", 32'(redir_done), 32'h1);
      step();
      step(1, 32'h300);
      got_q.delete();
      repeat (15) step();
      first_pc("second_redir", 32'h300);
      step(1, 32'h400);
      step(1, 32'h500);
      got_q.delete();
      repeat (15) step();
      first_pc("b2b_redir", 32'h500);

      // Table-driven redirect scenarios
      foreach (rows[r]) begin
         lat = rows[r].lat; gnt_pct = rows[r].gnt_pct; rdy_pct = rows[r].rdy_pct;
         if (rows[r].mode == 2) begin
            redir_done = 1'b0;
            for (int i = 0; i < 30 && !redir_done; i++) step(2, rows[r].tgt);
            chk("row_same_cycle_hit", 32'(redir_done), 32'h1);
         end else step(1, rows[r].tgt);
         got_q.delete();
         repeat (rows[r].cycles) step();
         first_pc("row_first_pc", rows[r].exp_first);
      end

      // PC wrap past the top of the address space
      lat = 1; gnt_pct = 100; rdy_pct = 100;
      step(1, 32'hFFFF_FFF8);
      got_q.delete();
      repeat (15) step();
      chk("wrap_len", 32'(got_q.size() >= 3), 32'h1);
      if (got_q.size() >= 3) begin
         chk("wrap_pc0", got_q[0], 32'hFFFF_FFF8);
         chk("wrap_pc1", got_q[1], 32'hFFFF_FFFC);
         chk("wrap_pc2", got_q[2], 32'h0000_0000);
      end

      // Asynchronous reset between clock edges
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(id_valid), 32'h0);
      chk("async_req", 32'(imem_req), 32'h0);
      chk("async_addr", imem_addr, 32'h0);
      quiet_inputs();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      got_q.delete();
      repeat (15) step();
      first_pc("restart_pc", 32'h0);

      quiet_inputs();
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
